// File: rtl/uart_frame_parser.sv
// Frame decoder behind the UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK.
// Publishes verified payloads; drops bad length, bad checksum or stalled frames.
module uart_frame_parser #(
    parameter int         MAX_PAYLOAD    = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 8700
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic [8*MAX_PAYLOAD-1:0] payload_out,
    output logic [3:0]               payload_len,
    output logic                     frame_valid,
    output logic                     frame_error,
    output logic [1:0]               error_code,
    output logic                     busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    state_t                   state, state_n;
    logic [8*MAX_PAYLOAD-1:0] wbuf, wbuf_n;
    logic [3:0]               idx, idx_n;
    logic [3:0]               len, len_n;
    logic [7:0]               sum, sum_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [8*MAX_PAYLOAD-1:0] payload_n;
    logic [3:0]               plen_n;
    logic [1:0]               code_n;
    logic                     fv_n, fe_n, busy_n;
    logic                     timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wbuf        <= '0;
            idx         <= '0;
            len         <= '0;
            sum         <= '0;
            cnt         <= '0;
            payload_out <= '0;
            payload_len <= '0;
            error_code  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            wbuf        <= wbuf_n;
            idx         <= idx_n;
            len         <= len_n;
            sum         <= sum_n;
            cnt         <= cnt_n;
            payload_out <= payload_n;
            payload_len <= plen_n;
            error_code  <= code_n;
            frame_valid <= fv_n;
            frame_error <= fe_n;
            busy        <= busy_n;
        end
    end

    // A byte landing on the final cycle wins over the timeout.
    assign timeout = (state != IDLE) && !byte_valid && (cnt == TO_LAST);

    always_comb begin
        state_n   = state;
        wbuf_n    = wbuf;
        idx_n     = idx;
        len_n     = len;
        sum_n     = sum;
        payload_n = payload_out;
        plen_n    = payload_len;
        code_n    = error_code;
        fv_n      = 1'b0;
        fe_n      = 1'b0;
        if (state == IDLE || byte_valid) cnt_n = '0;
        else                             cnt_n = cnt + CW'(1);

        unique case (state)
            IDLE: begin
                if (byte_valid && byte_in == SYNC_BYTE) state_n = LEN;
            end
            LEN: begin
                if (byte_valid) begin
                    if (byte_in == 8'd0 || byte_in > 8'(MAX_PAYLOAD)) begin
                        code_n  = 2'd1;
                        fe_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        len_n   = byte_in[3:0];
                        sum_n   = byte_in;
                        idx_n   = '0;
                        wbuf_n  = '0;
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_valid) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx == 4'(i)) wbuf_n[8*i +: 8] = byte_in;
                    end
                    sum_n = sum + byte_in;
                    idx_n = idx + 4'd1;
                    if (idx == len - 4'd1) state_n = CHK;
                end
            end
            CHK: begin
                if (byte_valid) begin
                    if (byte_in == sum) begin
                        payload_n = wbuf;
                        plen_n    = len;
                        fv_n      = 1'b1;
                    end else begin
                        code_n = 2'd2;
                        fe_n   = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (timeout) begin
            state_n = IDLE;
            code_n  = 2'd3;
            fe_n    = 1'b1;
            cnt_n   = '0;
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames, expected strobes
// queued at stimulus time and checked by an independent monitor.
module tb_uart_frame_parser;

    localparam int MAXP = 4;
    localparam int TO   = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic [8*MAXP-1:0] payload_out;
    logic [3:0]        payload_len;
    logic              frame_valid;
    logic              frame_error;
    logic [1:0]        error_code;
    logic              busy;

    uart_frame_parser #(
        .MAX_PAYLOAD(MAXP),
        .SYNC_BYTE(8'hAA),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .payload_out(payload_out),
        .payload_len(payload_len),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .error_code(error_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] pay;
        logic [3:0]  len;
        logic [1:0]  code;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   e_cyc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit is_err, input logic [31:0] pay,
                             input logic [3:0] len, input logic [1:0] code,
                             input int at);
        exp_t e;
        e.is_err = is_err;
        e.pay    = pay;
        e.len    = len;
        e.code   = code;
        e.at     = at;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (frame_valid || frame_error) begin
            if (frame_valid && frame_error) chk("both_strobes", 1, 0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", {frame_valid, frame_error}, 0);
            end else begin
                me = q.pop_front();
                chk("strobe_kind", frame_error, me.is_err);
                chk("payload_out", payload_out, me.pay);
                chk("payload_len", payload_len, me.len);
                chk("error_code", error_code, me.code);
                chk("busy_at_strobe", busy, 0);
                if (me.at >= 0) chk("strobe_cycle", 64'(cyc), 64'(me.at));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_payload", payload_out, 0);
        chk("rst_len", payload_len, 0);
        chk("rst_code", error_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {frame_valid, frame_error}, 0);

        // good frame immediately followed by a bad-checksum frame
        expect_ev(0, 32'h0000_2010, 4'd2, 2'd0, -1);
        expect_ev(1, 32'h0000_2010, 4'd2, 2'd2, -1);
        send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
        send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
        idle(3);

        // length 0 and length above maximum
        expect_ev(1, 32'h0000_2010, 4'd2, 2'd1, -1);
        send(8'hAA); send(8'h00);
        idle(2);
        chk("busy_after_len0", busy, 0);
        expect_ev(1, 32'h0000_2010, 4'd2, 2'd1, -1);
        send(8'hAA); send(8'h05);
        idle(2);
        chk("busy_after_len5", busy, 0);

        // timeout fires TO cycles after the last sampled byte
        send(8'hAA); send(8'h02); send(8'h10);
        e_cyc = cyc;
        expect_ev(1, 32'h0000_2010, 4'd2, 2'd3, e_cyc + TO);
        idle(TO + 5);

        // byte on the final cycle rescues the frame
        send(8'hAA); send(8'h02); send(8'h10);
        e_cyc = cyc;
        while (cyc < e_cyc + TO - 1) @(negedge clk);
        chk("busy_before_timeout", busy, 1);
        expect_ev(0, 32'h0000_2010, 4'd2, 2'd3, -1);
        send(8'h20); send(8'h32);
        idle(TO + 5);

        // leading garbage and checksum wrap
        expect_ev(0, 32'hFFFF_FFFF, 4'd4, 2'd3, -1);
        send(8'h12); send(8'h34);
        send(8'hAA); send(8'h04);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h00);
        idle(3);

        // reset mid-frame discards everything
        send(8'hAA); send(8'h02); send(8'h10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(8'h20); send(8'h32);
        idle(3);
        chk("mrst_payload", payload_out, 0);
        chk("mrst_len", payload_len, 0);
        chk("mrst_code", error_code, 0);
        chk("mrst_busy", busy, 0);

        expect_ev(0, 32'h0000_007F, 4'd1, 2'd0, -1);
        send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
        idle(5);

        chk("queue_drained", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
